hilo_unit: RTL
==============

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 40: maximum DIV_WAIT cycles before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port write_hi  input  1  MTHI commit from exe.
REQ-005 SHALL have port write_lo  input  1  MTLO commit from exe.
REQ-006 SHALL have port mul_we  input  1  MULT/MULTU commit; writes HI and LO.
REQ-007 SHALL have port hi_in  input  32  HI write data for write_hi and mul_we.
REQ-008 SHALL have port lo_in  input  32  LO write data for write_lo and mul_we.
REQ-009 SHALL have port hilo_rd  input  1  exe is executing MFHI/MFLO this cycle.
REQ-010 SHALL have port div_start  input  1  exe has issued DIV/DIVU to the divider this cycle.
REQ-011 SHALL have port div_valid  input  1  divider result valid (m_axis_dout_tvalid).
REQ-012 SHALL have port div_dout  input  64  divider result: [63:32] quotient, [31:0] remainder.
REQ-013 SHALL have port flush  input  1  pipeline flush; kills the in-flight divide.
REQ-014 SHALL have port hi_out  output  32  HI value to exe i_hi.
REQ-015 SHALL have port lo_out  output  32  LO value to exe i_lo.
REQ-016 SHALL have port stall  output  1  freeze pipeline at exe and upstream.
REQ-017 SHALL have port div_err  output  1  one-cycle pulse on divide timeout.

Function
REQ-018 SHALL implement the states IDLE, DIV_WAIT and DIV_DRAIN.
REQ-019 IDLE: div_start&!flush SHALL enter DIV_WAIT and clear the 6-bit wait counter.
REQ-020 DIV_WAIT: div_valid SHALL latch HI=div_dout[31:0] and LO=div_dout[63:32], then return to IDLE.
REQ-021 DIV_WAIT: stall SHALL be 1 every cycle except the div_valid cycle, when it SHALL be 0.
REQ-022 DIV_WAIT: flush without div_valid SHALL enter DIV_DRAIN with no HI/LO update; flush with div_valid SHALL write HI/LO and go to IDLE.
REQ-023 DIV_DRAIN: div_valid SHALL be discarded and the state SHALL go to IDLE.
REQ-024 DIV_DRAIN: stall SHALL equal hilo_rd|write_hi|write_lo|mul_we|div_start.
REQ-025 DIV_WAIT/DIV_DRAIN: when the counter reaches DIV_TIMEOUT-1 without div_valid, the state SHALL go to IDLE, pulse div_err for one cycle, and leave HI/LO unchanged.
REQ-026 In IDLE, HI/LO writes SHALL commit at the clock edge; priority mul_we > write_hi/write_lo; write_hi and write_lo together SHALL both commit.
REQ-027 While stall=1, writes SHALL be ignored.
REQ-028 In IDLE, stall SHALL be 0.
REQ-029 hi_out/lo_out SHALL present the registered HI/LO values, subject to forwarding (REQ-033).
REQ-030 Divide-by-zero results SHALL be written as delivered by the divider, with no special casing.

Reset
REQ-031 rst SHALL asynchronously force: state=IDLE, HI=LO=0, counter=0, stall=0, div_err=0, hi_out=lo_out=0.
REQ-032 rst asserted mid-divide SHALL return to IDLE; a later div_valid arriving in IDLE SHALL be ignored.

Configuration
REQ-033 With macro HILO_FWD_EN defined, hi_out/lo_out SHALL combinationally bypass the same-cycle committing write data (HI/LO write or div_valid result); without it, outputs SHALL be register-only, and exe SHALL see the new value one cycle later.

Structure
REQ-034 The state encoding, DIV_TIMEOUT default and div_dout field offsets SHALL live in the shared package alongside the ALUControl defines.
REQ-035 HI/LO storage with its write-priority mux SHALL be a sub-module named hilo_regfile; the FSM and counter SHALL stay in hilo_unit.

Verification
REQ-036 Reset, then mul_we=1, hi_in=32'h1, lo_in=32'hFFFF_FFFE -> next cycle hi_out=1, lo_out=FFFF_FFFE.
REQ-037 div_start, then div_valid 36 cycles later with div_dout={32'd7,32'd3} -> stall=1 for 35 cycles, then LO=7, HI=3, state IDLE.
REQ-038 div_start, flush 5 cycles later, then div_valid with a nonzero result -> HI/LO unchanged; hilo_rd during DIV_DRAIN -> stall=1.
REQ-039 div_start with no div_valid -> div_err pulses in cycle DIV_TIMEOUT (40), stall drops, HI/LO unchanged.
REQ-040 write_hi and mul_we in the same cycle -> HI=hi_in from mul; with HILO_FWD_EN, hi_out shows hi_in in the same cycle.
REQ-041 rst asserted mid-DIV_WAIT, then div_valid -> HI=LO=0, stall=0.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: FSM states, divider timeout default,
// divider result field offsets and the ALU control encodings used by exe.
package hilo_unit_pkg;

    localparam int DATA_W          = 32;
    localparam int DIV_TIMEOUT_DEF = 40;
    localparam int DIV_CNT_W       = 6;

    // Divider result layout: quotient in the upper word, remainder in the lower word
    localparam int DOUT_QUO_LSB = 32;
    localparam int DOUT_REM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIV_WAIT  = 2'd1,
        DIV_DRAIN = 2'd2
    } hilo_state_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_NOR  = 4'd4,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_SLTU = 4'd11,
        ALU_LUI  = 4'd12
    } alu_ctrl_e;

endpackage

// File: rtl/hilo_regfile.sv
// HI/LO register pair with write-priority mux: divider result > MULT > MTHI/MTLO.
// Define HILO_FWD_EN to bypass same-cycle write data onto the outputs.
module hilo_regfile
    import hilo_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              div_we,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    input  logic              mul_we,
    input  logic              write_hi,
    input  logic              write_lo,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_d;
    logic              hi_we;
    logic              lo_we;

    always_comb begin
        hi_d  = hi_in;
        lo_d  = lo_in;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (div_we) begin
            hi_d  = div_hi;
            lo_d  = div_lo;
            hi_we = 1'b1;
            lo_we = 1'b1;
        end else if (mul_we) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
        end else begin
            hi_we = write_hi;
            lo_we = write_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
        end
    end

`ifdef HILO_FWD_EN
    // Reset must still force zero outputs even if writes are asserted
    assign hi_out = (hi_we && !rst) ? hi_d : hi_q;
    assign lo_out = (lo_we && !rst) ? lo_d : lo_q;
`else
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`endif

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: owns the HI/LO registers and tracks outstanding divides, stalling
// exe until the divider answers, is flushed, or times out. Optional: HILO_FWD_EN.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_hi,
    input  logic              write_lo,
    input  logic              mul_we,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic              hilo_rd,
    input  logic              div_start,
    input  logic              div_valid,
    input  logic [63:0]       div_dout,
    input  logic              flush,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              stall,
    output logic              div_err
);

    hilo_state_e          state;
    hilo_state_e          state_next;
    logic [DIV_CNT_W-1:0] cnt;
    logic                 timeout;
    logic                 div_we;
    logic                 wr_ok;

    assign timeout = (cnt == DIV_CNT_W'(DIV_TIMEOUT - 1));

    // Timeout is checked before flush so a drained divide can never outlive the limit
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        div_err    = 1'b0;
        div_we     = 1'b0;
        wr_ok      = 1'b0;
        case (state)
            IDLE: begin
                wr_ok = 1'b1;
                if (div_start && !flush) state_next = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_valid) begin
                    div_we     = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                    if (timeout) begin
                        div_err    = 1'b1;
                        state_next = IDLE;
                    end else if (flush) begin
                        state_next = DIV_DRAIN;
                    end
                end
            end
            DIV_DRAIN: begin
                stall = hilo_rd | write_hi | write_lo | mul_we | div_start;
                if (div_valid) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    div_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) cnt <= '0;
            else               cnt <= cnt + 1'b1;
        end
    end

    hilo_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .div_we   (div_we),
        .div_hi   (div_dout[DOUT_REM_LSB +: DATA_W]),
        .div_lo   (div_dout[DOUT_QUO_LSB +: DATA_W]),
        .mul_we   (mul_we   & wr_ok),
        .write_hi (write_hi & wr_ok),
        .write_lo (write_lo & wr_ok),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

endmodule
